// File: rtl/aes_decryption_if.sv
// Handshake and data bus for the iterative AES-128 decryption core.
interface aes_decryption_if;
    logic         start;
    logic [127:0] data;
    logic [127:0] key;
    logic [127:0] plain;
    logic         done;
    logic         busy;

    modport master (output start, data, key, input plain, done, busy);
    modport slave  (input start, data, key, output plain, done, busy);
endinterface

// File: rtl/aes_decryption.sv
// Iterative AES-128 decryption: one inverse round per clock, round keys derived on the fly.
// Optional key cache (skip forward expansion when the key repeats): define AES_DEC_KEY_CACHE_EN.
//
// state | meaning
// IDLE  | waiting for start; inputs latched on the accepting edge
// KEXP  | forward key expansion rk0 -> rk10, one round key per cycle
// ARK   | initial AddRoundKey with rk10, step key back to rk9
// ROUND | inverse rounds 9..1, key steps back one round per cycle
// FINAL | last inverse round without InvMixColumns, pulse done
module aes_decryption (
    input  logic            clk,
    input  logic            rst_n,
    aes_decryption_if.slave bus
);
    typedef enum logic [2:0] {IDLE, KEXP, ARK, ROUND, FINAL} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] m9_0, m9_1, m9_2, m9_3, m11_0, m11_1, m11_2, m11_3;
        logic [7:0] m13_0, m13_1, m13_2, m13_3, m14_0, m14_1, m14_2, m14_3;
        {a0, a1, a2, a3} = c;
        m9_0  = xt(xt(xt(a0))) ^ a0;           m9_1  = xt(xt(xt(a1))) ^ a1;
        m9_2  = xt(xt(xt(a2))) ^ a2;           m9_3  = xt(xt(xt(a3))) ^ a3;
        m11_0 = m9_0 ^ xt(a0);                 m11_1 = m9_1 ^ xt(a1);
        m11_2 = m9_2 ^ xt(a2);                 m11_3 = m9_3 ^ xt(a3);
        m13_0 = m9_0 ^ xt(xt(a0));             m13_1 = m9_1 ^ xt(xt(a1));
        m13_2 = m9_2 ^ xt(xt(a2));             m13_3 = m9_3 ^ xt(xt(a3));
        m14_0 = m13_0 ^ a0 ^ xt(a0);           m14_1 = m13_1 ^ a1 ^ xt(a1);
        m14_2 = m13_2 ^ a2 ^ xt(a2);           m14_3 = m13_3 ^ a3 ^ xt(a3);
        return {m14_0 ^ m11_1 ^ m13_2 ^ m9_3,
                m9_0  ^ m14_1 ^ m11_2 ^ m13_3,
                m13_0 ^ m9_1  ^ m14_2 ^ m11_3,
                m11_0 ^ m13_1 ^ m9_2  ^ m14_3};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
    endfunction

    // Byte k = column*4 + row sits at bits [127-8k -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   st_q, st_d;
    logic [127:0]   rk_q, rk_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   plain_q, plain_d;
    logic           done_q, done_d;
`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0]   cache_key_q, cache_key_d;
    logic [127:0]   cache_rk10_q, cache_rk10_d;
    logic           cache_vld_q, cache_vld_d;
`endif

    logic [3:0]     rc_idx;
    logic [31:0]    kw_in, kw_sub, kw_f;
    logic [31:0]    fw0, fw1, fw2, fw3;
    logic [127:0]   rk_fwd, rk_inv, inv_core;

    // One 4-byte S-box bank serves both directions: w3 going forward, w3^w2 going back.
    always_comb begin
        rc_idx = (state_q == ARK) ? 4'd10 : cnt_q;
        kw_in  = (state_q == KEXP) ? rk_q[31:0] : (rk_q[31:0] ^ rk_q[63:32]);
        kw_sub = {SBOX[kw_in[23:16]], SBOX[kw_in[15:8]], SBOX[kw_in[7:0]], SBOX[kw_in[31:24]]};
        kw_f   = kw_sub ^ {rcon(rc_idx), 24'h0};
        fw0    = rk_q[127:96] ^ kw_f;
        fw1    = rk_q[95:64] ^ fw0;
        fw2    = rk_q[63:32] ^ fw1;
        fw3    = rk_q[31:0] ^ fw2;
        rk_fwd = {fw0, fw1, fw2, fw3};
        rk_inv = {rk_q[127:96] ^ kw_f, rk_q[127:96] ^ rk_q[95:64],
                  rk_q[95:64] ^ rk_q[63:32], rk_q[63:32] ^ rk_q[31:0]};
        inv_core = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_q;
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        cnt_d   = cnt_q;
        plain_d = plain_q;
        done_d  = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
        cache_key_d  = cache_key_q;
        cache_rk10_d = cache_rk10_q;
        cache_vld_d  = cache_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    st_d  = bus.data;
                    cnt_d = 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (cache_vld_q && (bus.key == cache_key_q)) begin
                        rk_d    = cache_rk10_q;
                        state_d = ARK;
                    end else begin
                        rk_d        = bus.key;
                        cache_key_d = bus.key;
                        state_d     = KEXP;
                    end
`else
                    rk_d    = bus.key;
                    state_d = KEXP;
`endif
                end
            end
            KEXP: begin
                rk_d  = rk_fwd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd10) begin
                    state_d = ARK;
`ifdef AES_DEC_KEY_CACHE_EN
                    cache_rk10_d = rk_fwd;
                    cache_vld_d  = 1'b1;
`endif
                end
            end
            ARK: begin
                st_d    = st_q ^ rk_q;
                rk_d    = rk_inv;
                cnt_d   = 4'd9;
                state_d = ROUND;
            end
            ROUND: begin
                st_d  = inv_mix_columns(inv_core);
                rk_d  = rk_inv;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = FINAL;
            end
            FINAL: begin
                plain_d = inv_core;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            cnt_q   <= '0;
            plain_q <= '0;
            done_q  <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_key_q  <= '0;
            cache_rk10_q <= '0;
            cache_vld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            cnt_q   <= cnt_d;
            plain_q <= plain_d;
            done_q  <= done_d;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_key_q  <= cache_key_d;
            cache_rk10_q <= cache_rk10_d;
            cache_vld_q  <= cache_vld_d;
`endif
        end
    end

    assign bus.plain = plain_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_aes_decryption.sv
// Self-checking bench for aes_decryption: FIPS vectors, handshake corner cases and random loopback.
module tb_aes_decryption;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    aes_decryption_if bus();
    aes_decryption dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]   sbox_m [256];
    bit           cache_vld_m;
    logic [127:0] cache_key_m;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box built from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Textbook AES-128 encryption; the bench checks decryption by round trip through it.
    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int j = 0; j < 16; j++) s[j] = sbox_m[s[j]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
            for (int c = 0; c < 4; c++) begin
                if (r != 10) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int q = 0; q < 4; q++) s[4*c+q] = t[4*c+q];
                end
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
        end
        o = '0;
        for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
        return o;
    endfunction

    function automatic int exp_lat(input logic [127:0] k);
`ifdef AES_DEC_KEY_CACHE_EN
        if (cache_vld_m && k == cache_key_m) return 11;
`endif
        return 21;
    endfunction

    // A miss that runs to completion expands the key, so it becomes the cached one.
    task automatic note_key(input logic [127:0] k);
        if (exp_lat(k) == 21) begin
            cache_key_m = k;
            cache_vld_m = 1'b1;
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] d,
                             input logic [127:0] exp_p);
        int lat, want;
        want = exp_lat(k);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.data = d; bus.key = k;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.data = rnd128(); bus.key = rnd128();
        chk({tag, "_busy"}, 128'(bus.busy), 128'(1));
        wait_done(lat);
        note_key(k);
        chk({tag, "_lat"}, 128'(lat), 128'(want));
        chk({tag, "_plain"}, bus.plain, exp_p);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 128'(bus.done), 128'(0));
        chk({tag, "_hold"}, bus.plain, exp_p);
    endtask

    initial begin
        logic [127:0] k, pt, ct, k2, pt2, ct2;
        int lat, want, nd, first_lat;
        logic [127:0] cap;

        build_sbox();
        cache_vld_m = 1'b0;
        cache_key_m = '0;
        rst_n = 1'b0; bus.start = 1'b0; bus.data = '0; bus.key = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_plain", bus.plain, 128'h0);
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        rst_n = 1'b1;

        run_block("c1", 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
        run_block("two_one", 128'h5468617473206D79204B756E67204675,
                  128'h29C3505F571420F6402299B31A02D73A, 128'h54776F204F6E65204E696E652054776F);
        run_block("two_one_rep", 128'h5468617473206D79204B756E67204675,
                  128'h29C3505F571420F6402299B31A02D73A, 128'h54776F204F6E65204E696E652054776F);
        run_block("fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734);

        // Starts at cycles 5 and 15 of a running request must be ignored.
        k = rnd128(); pt = rnd128(); ct = aes_enc(k, pt);
        want = exp_lat(k);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.data = ct; bus.key = k;
        @(posedge clk); #1;
        bus.start = 1'b0;
        nd = 0; first_lat = 0; cap = '0;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                nd++;
                if (first_lat == 0) begin
                    first_lat = n;
                    cap = bus.plain;
                end
            end
            bus.start = (n == 4 || n == 14);
            bus.data  = rnd128();
            bus.key   = rnd128();
        end
        note_key(k);
        chk("ign_ndone", 128'(nd), 128'(1));
        chk("ign_lat", 128'(first_lat), 128'(want));
        chk("ign_plain", cap, pt);
        chk("ign_idle", 128'(bus.busy), 128'(0));

        // Start held high: ignored while busy and in FINAL, accepted on the edge after done.
        k = 128'h000102030405060708090a0b0c0d0e0f;
        k2 = 128'h5468617473206D79204B756E67204675; pt2 = rnd128(); ct2 = aes_enc(k2, pt2);
        want = exp_lat(k);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.data = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; bus.key = k;
        @(posedge clk); #1;
        wait_done(lat);
        note_key(k);
        chk("hold_lat1", 128'(lat), 128'(want));
        chk("hold_plain1", bus.plain, 128'h00112233445566778899aabbccddeeff);
        bus.data = ct2; bus.key = k2;
        want = exp_lat(k2);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("hold_busy2", 128'(bus.busy), 128'(1));
        wait_done(lat);
        note_key(k2);
        chk("hold_lat2", 128'(lat), 128'(want));
        chk("hold_plain2", bus.plain, pt2);

        // Reset at cycle 8 aborts with no done; cache is gone afterwards.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.data = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        bus.key = 128'h000102030405060708090a0b0c0d0e0f;
        @(posedge clk); #1;
        bus.start = 1'b0;
        nd = 0;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
            if (bus.done) nd++;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ndone", 128'(nd), 128'(0));
        chk("abort_plain", bus.plain, 128'h0);
        chk("abort_done", 128'(bus.done), 128'(0));
        chk("abort_busy", 128'(bus.busy), 128'(0));
        cache_vld_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_block("c1_after_rst", 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);

        // Random round trips; keys are reused in runs of three.
        k = rnd128();
        for (int i = 0; i < 100; i++) begin
            if (i % 3 == 0) k = rnd128();
            pt = rnd128();
            run_block("loop", k, aes_enc(k, pt), pt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
